// File: rtl/adc_pulse_capture.sv
// rtl/adc_pulse_capture.sv - ADC pulse capture: threshold trigger, pre/post ring window, readout and peak (option: ADC_BASELINE_SUB_EN)
module adc_pulse_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int PRE    = 8,
  parameter int THRESH = 600
) (
  input  logic              CLK_i,
  input  logic              RSTn_i,
  output logic              cs_o,
  input  logic [DATA_W-1:0] adc_i,
  input  logic              arm_i,
  input  logic              abort_i,
  output logic              trig_o,
  output logic              done_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_last_o,
  output logic [DATA_W-1:0] peak_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PRE);
  localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_POST,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic              cs_q, cs_d;
  logic              s_valid_q;
  logic [AW-1:0]     wp_q, wp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     tptr_q, tptr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [DATA_W-1:0] pre_max;
  logic              ring_we;
  logic              trig_pulse;
  logic [DATA_W-1:0] ring_q [DEPTH];

`ifdef ADC_BASELINE_SUB_EN
  localparam int SW = DATA_W + PW;
  logic [SW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0] base_q, base_d;

  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction
`endif

  // Pre-trigger peak contribution: WAIT_TRIG samples are all below threshold, so only
  // ARM-phase samples (ring[0..PRE-1]) still inside the window can exceed the trigger.
  // cnt_q holds the number of WAIT_TRIG samples seen so far (saturating at PRE).
  always_comb begin
    pre_max = '0;
    for (int i = 0; i < PRE; i++) begin
      if ((CW'(i) >= cnt_q) && (ring_q[AW'(i)] > pre_max)) pre_max = ring_q[AW'(i)];
    end
  end

  // Next-state, sample write control and readout logic
  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    wp_d       = wp_q;
    cnt_d      = cnt_q;
    tptr_d     = tptr_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    peak_d     = peak_q;
    ring_we    = 1'b0;
    trig_pulse = 1'b0;
`ifdef ADC_BASELINE_SUB_EN
    sum_d      = sum_q;
    base_d     = base_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
      cs_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cs_d = 1'b0;
          if (arm_i) begin
            state_d = S_ARM;
            cs_d    = 1'b1;
            wp_d    = '0;
            cnt_d   = '0;
            peak_d  = '0;
`ifdef ADC_BASELINE_SUB_EN
            sum_d   = '0;
            base_d  = '0;
`endif
          end
        end
        S_ARM: begin
          cs_d = 1'b1;
          if (s_valid_q) begin
            ring_we = 1'b1;
            wp_d    = wp_q + AW'(1);
`ifdef ADC_BASELINE_SUB_EN
            sum_d   = sum_q + SW'(adc_i);
`endif
            if (cnt_q == CW'(PRE - 1)) begin
              state_d = S_WAIT_TRIG;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_WAIT_TRIG: begin
          cs_d = 1'b1;
          if (s_valid_q) begin
            ring_we = 1'b1;
            wp_d    = wp_q + AW'(1);
            if (adc_i >= THRESH_V) begin
              trig_pulse = 1'b1;
              tptr_d     = wp_q;
              state_d    = S_POST;
              cnt_d      = CW'(1);
              peak_d     = (adc_i > pre_max) ? adc_i : pre_max;
`ifdef ADC_BASELINE_SUB_EN
              base_d     = DATA_W'(sum_q >> PW);
`endif
            end else begin
              if (cnt_q < CW'(PRE)) cnt_d = cnt_q + CW'(1);
`ifdef ADC_BASELINE_SUB_EN
              // Sliding sum of the last PRE samples: add newest, drop the one PRE writes back
              sum_d = sum_q + SW'(adc_i) - SW'(ring_q[wp_q - AW'(PRE)]);
`endif
            end
          end
        end
        S_POST: begin
          if (s_valid_q) begin
            ring_we = 1'b1;
            wp_d    = wp_q + AW'(1);
            if (adc_i > peak_q) peak_d = adc_i;
            if (cnt_q == CW'(DEPTH - PRE - 1)) begin
              cs_d      = 1'b0;
              state_d   = S_READY;
              rd_addr_d = tptr_q - AW'(PRE);
              rd_cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_READY: begin
          cs_d = 1'b0;
          if (rd_en_i) begin
`ifdef ADC_BASELINE_SUB_EN
            rd_data_d = sat_sub(ring_q[rd_addr_q], base_q);
`else
            rd_data_d = ring_q[rd_addr_q];
`endif
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_cnt_q == AW'(DEPTH - 1));
            rd_addr_d  = rd_addr_q + AW'(1);
            rd_cnt_d   = rd_cnt_q + AW'(1);
            if (rd_cnt_q == AW'(DEPTH - 1)) state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cs_d    = 1'b0;
        end
      endcase
    end
  end

  // Control and datapath registers
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q    <= S_IDLE;
      cs_q       <= 1'b0;
      s_valid_q  <= 1'b0;
      wp_q       <= '0;
      cnt_q      <= '0;
      tptr_q     <= '0;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      peak_q     <= '0;
`ifdef ADC_BASELINE_SUB_EN
      sum_q      <= '0;
      base_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      s_valid_q  <= cs_q;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      tptr_q     <= tptr_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      peak_q     <= peak_d;
`ifdef ADC_BASELINE_SUB_EN
      sum_q      <= sum_d;
      base_q     <= base_d;
`endif
    end
  end

  // Ring buffer storage; contents carry no reset value
  always_ff @(posedge CLK_i) begin
    if (ring_we) ring_q[wp_q] <= adc_i;
  end

  assign cs_o       = cs_q;
  assign trig_o     = trig_pulse;
  assign done_o     = (state_q == S_READY);
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
`ifdef ADC_BASELINE_SUB_EN
  assign peak_o     = sat_sub(peak_q, base_q);
`else
  assign peak_o     = peak_q;
`endif

endmodule

// File: tb/tb_adc_pulse_capture.sv
// tb/tb_adc_pulse_capture.sv - testbench for adc_pulse_capture
module tb_adc_pulse_capture;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int PRE   = 8;

  logic          CLK_i   = 1'b0;
  logic          RSTn_i  = 1'b0;
  logic          cs_o;
  logic [DW-1:0] adc_i   = '0;
  logic          arm_i   = 1'b0;
  logic          abort_i = 1'b0;
  logic          trig_o;
  logic          done_o;
  logic          rd_en_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_last_o;
  logic [DW-1:0] peak_o;

  adc_pulse_capture #(.DATA_W(DW), .DEPTH(DEPTH), .PRE(PRE), .THRESH(600)) dut (
    .CLK_i(CLK_i), .RSTn_i(RSTn_i), .cs_o(cs_o), .adc_i(adc_i), .arm_i(arm_i),
    .abort_i(abort_i), .trig_o(trig_o), .done_o(done_o), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o), .peak_o(peak_o)
  );

  always #5 CLK_i = ~CLK_i;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   mode_sel = 0;
  int   base_n   = 0;
  int   sidx     = 0;
  logic cs_seen  = 1'b0;
  int   trig_cnt = 0;
  int   trig_at  = 0;

  // Source model: sample n (1-based since arm) for each stimulus pattern
  function automatic logic [DW-1:0] src_val(input int m, input int n);
    int v;
    case (m)
      1:       v = (n == 20) ? 900 : 500;
      2:       v = (n == 3) ? 900 : ((n == 15) ? 700 : 500);
      3:       v = (n == 50) ? 900 : 100 + n;
      4:       v = (n == 12) ? 900 : 500;
      5:       v = (n == 2) ? 950 : ((n == 9) ? 700 : 500);
      default: v = 500;
    endcase
    return DW'(v);
  endfunction

  // Expected readout word k for a trigger at sample trig_n
  function automatic logic [DW-1:0] exp_word(input int m, input int trig_n, input int k);
    int v;
    v = int'(src_val(m, trig_n - PRE + k));
`ifdef ADC_BASELINE_SUB_EN
    begin
      int s;
      s = 0;
      for (int i = 1; i <= PRE; i++) s += int'(src_val(m, trig_n - i));
      v = v - (s / PRE);
      if (v < 0) v = 0;
    end
`endif
    return DW'(v);
  endfunction

  always @(negedge CLK_i) cs_seen = cs_o;

  // ADC source: one sample the cycle after cs_o is seen high
  always @(posedge CLK_i) begin
    #1;
    if (cs_seen) begin
      sidx  = sidx + 1;
      adc_i = src_val(mode_sel, sidx - base_n);
    end
  end

  always @(negedge CLK_i) begin
    if (trig_o) begin
      trig_cnt = trig_cnt + 1;
      trig_at  = sidx - base_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_arm(input int m);
    @(negedge CLK_i);
    mode_sel = m;
    base_n   = sidx;
    arm_i    = 1'b1;
    @(negedge CLK_i);
    arm_i = 1'b0;
    chk("arm_cs", cs_o, 1);
    chk("arm_peak_clear", peak_o, 0);
  endtask

  typedef struct {
    int            mode;
    int            trig_n;
    logic [DW-1:0] w0;
    logic [DW-1:0] w8;
    logic [DW-1:0] peak;
  } scen_t;

  scen_t tbl[4];

  initial begin
    int t0;
    bit bad;
`ifdef ADC_BASELINE_SUB_EN
    tbl[0] = '{1, 20, 16'd0, 16'd400, 16'd400};
    tbl[1] = '{2, 15, 16'd0, 16'd200, 16'd200};
    tbl[2] = '{3, 50, 16'd0, 16'd755, 16'd755};
    tbl[3] = '{5,  9, 16'd0, 16'd144, 16'd394};
`else
    tbl[0] = '{1, 20, 16'd500, 16'd900, 16'd900};
    tbl[1] = '{2, 15, 16'd500, 16'd700, 16'd700};
    tbl[2] = '{3, 50, 16'd142, 16'd900, 16'd900};
    tbl[3] = '{5,  9, 16'd500, 16'd700, 16'd950};
`endif

    // Reset values
    repeat (2) @(negedge CLK_i);
    chk("rst_cs", cs_o, 0);
    chk("rst_trig", trig_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_last", rd_last_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_peak", peak_o, 0);
    RSTn_i = 1'b1;
    @(negedge CLK_i);

    // Simultaneous arm and abort in IDLE stays IDLE
    arm_i = 1'b1; abort_i = 1'b1;
    @(negedge CLK_i);
    arm_i = 1'b0; abort_i = 1'b0;
    chk("arm_abort_cs", cs_o, 0);
    @(negedge CLK_i);
    chk("arm_abort_cs2", cs_o, 0);

    // Constant sub-threshold source never triggers
    t0 = trig_cnt;
    do_arm(0);
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK_i);
      if (cs_o !== 1'b1 || done_o !== 1'b0) bad = 1'b1;
    end
    chk("const_cs_high_no_done", bad, 0);
    chk("const_no_trig", trig_cnt - t0, 0);
    abort_i = 1'b1;
    @(negedge CLK_i);
    abort_i = 1'b0;
    chk("abort_wait_cs", cs_o, 0);
    chk("abort_wait_done", done_o, 0);
    repeat (3) @(negedge CLK_i);

    // Abort during POST
    t0 = trig_cnt;
    do_arm(4);
    for (int i = 0; i < 100 && trig_cnt == t0; i++) @(negedge CLK_i);
    chk("abort_test_trig", trig_cnt - t0, 1);
    repeat (5) @(negedge CLK_i);
    abort_i = 1'b1;
    @(negedge CLK_i);
    abort_i = 1'b0;
    chk("abort_post_cs", cs_o, 0);
    chk("abort_post_done", done_o, 0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_i);
      if (done_o !== 1'b0 || cs_o !== 1'b0) bad = 1'b1;
    end
    chk("abort_post_stays_idle", bad, 0);

    // Table-driven captures with full readout
    for (int s = 0; s < 4; s++) begin
      t0 = trig_cnt;
      do_arm(tbl[s].mode);
      for (int i = 0; i < 400 && done_o !== 1'b1; i++) @(negedge CLK_i);
      chk("done", done_o, 1);
      chk("trig_count", trig_cnt - t0, 1);
      chk("trig_sample", trig_at, tbl[s].trig_n);
      chk("ready_cs", cs_o, 0);
      chk("peak", peak_o, tbl[s].peak);
      for (int j = 0; j <= DEPTH; j++) begin
        if (j > 0) begin
          int k;
          logic [DW-1:0] e;
          k = j - 1;
          if (k == 0) e = tbl[s].w0;
          else if (k == PRE) e = tbl[s].w8;
          else e = exp_word(tbl[s].mode, tbl[s].trig_n, k);
          chk("rd_valid", rd_valid_o, 1);
          chk("rd_data", rd_data_o, e);
          chk("rd_last", rd_last_o, (k == DEPTH - 1) ? 1 : 0);
        end
        rd_en_i = (j < DEPTH);
        if (j < DEPTH) @(negedge CLK_i);
      end
      rd_en_i = 1'b0;
      chk("post_read_done", done_o, 0);
      chk("post_read_cs", cs_o, 0);
      chk("peak_held", peak_o, tbl[s].peak);
      @(negedge CLK_i);
    end

    // Readout request ignored in IDLE
    rd_en_i = 1'b1;
    @(negedge CLK_i);
    rd_en_i = 1'b0;
    chk("idle_rd_ignored", rd_valid_o, 0);

    // Asynchronous reset mid-capture
    do_arm(1);
    repeat (15) @(negedge CLK_i);
    RSTn_i = 1'b0;
    #1;
    chk("rst_mid_cs", cs_o, 0);
    chk("rst_mid_peak", peak_o, 0);
    chk("rst_mid_done", done_o, 0);
    @(negedge CLK_i);
    RSTn_i = 1'b1;
    repeat (3) @(negedge CLK_i);
    chk("rst_mid_idle", cs_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
